// File: rtl/regfile_wr_arb_pkg.sv
// Shared definitions for the register-file write arbiter: default bus widths,
// the zero word, and the source identifiers.
package regfile_wr_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding register for a writeback source. It holds a valid bit,
// the target address and data, and an age bit that is set while this entry is the older one.
module rf_wr_slot
  import regfile_wr_arb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              age_d,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic              age,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      age   <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      valid <= load | (valid & ~drain);
      age   <= age_d;
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Two-source write arbiter in front of the register-file write port. The
// optional REGFILE_ARB_RR_EN macro selects round-robin over fixed s0 priority.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q0_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q0_hit,
  output logic              q1_hit
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_WORD);

  logic              running;
  logic              prefer0;
  logic [1:0]        slot_v, slot_age, grant, load, v_nx, age_nx;
  logic [ADDR_W-1:0] slot_addr [2];
  logic [DATA_W-1:0] slot_data [2];

  // Ready stays low until the first edge after reset release.
  assign s0_ready = running & (~slot_v[0] | grant[0]);
  assign s1_ready = running & (~slot_v[1] | grant[1]);

  // Address-0 transfers are handshaken but never stored.
  assign load[0] = s0_valid & s0_ready & (s0_addr != ZERO_ADDR);
  assign load[1] = s1_valid & s1_ready & (s1_addr != ZERO_ADDR);

  always_comb begin
    grant = 2'b00;
    if (slot_v[0] && slot_v[1]) begin
      if (slot_addr[0] == slot_addr[1]) grant = slot_age[1] ? 2'b10 : 2'b01;
      else                              grant = prefer0     ? 2'b01 : 2'b10;
    end else begin
      grant = slot_v;
    end
  end

  // A surviving entry is older than a fresh one; on a same-edge load slot 1 wins.
  assign v_nx      = load | (slot_v & ~grant);
  assign age_nx[0] = v_nx[0] & (~v_nx[1] | (~load[0] & (load[1] | slot_age[0])));
  assign age_nx[1] = v_nx[1] & (~v_nx[0] | load[0] | (~load[1] & slot_age[1]));

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[0]),
    .drain    (grant[0]),
    .age_d    (age_nx[0]),
    .load_addr(s0_addr),
    .load_data(s0_data),
    .valid    (slot_v[0]),
    .age      (slot_age[0]),
    .addr     (slot_addr[0]),
    .data     (slot_data[0])
  );

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[1]),
    .drain    (grant[1]),
    .age_d    (age_nx[1]),
    .load_addr(s1_addr),
    .load_data(s1_data),
    .valid    (slot_v[1]),
    .age      (slot_age[1]),
    .addr     (slot_addr[1]),
    .data     (slot_data[1])
  );

`ifdef REGFILE_ARB_RR_EN
  src_e rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_ptr <= SRC0;
    else if (|grant) rr_ptr <= grant[0] ? SRC1 : SRC0;
  end

  assign prefer0 = (rr_ptr == SRC0);
`else
  assign prefer0 = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      we      <= 1'b0;
      waddr   <= ZERO_ADDR;
      wdata   <= DATA_W'(RF_ZERO_WORD);
    end else begin
      running <= 1'b1;
      we      <= |grant;
      if (grant[1]) begin
        waddr <= slot_addr[1];
        wdata <= slot_data[1];
      end else if (grant[0]) begin
        waddr <= slot_addr[0];
        wdata <= slot_data[0];
      end
    end
  end

  assign q0_hit = (q0_addr != ZERO_ADDR) &&
                  ((slot_v[0] && slot_addr[0] == q0_addr) ||
                   (slot_v[1] && slot_addr[1] == q0_addr) ||
                   (we && waddr == q0_addr));
  assign q1_hit = (q1_addr != ZERO_ADDR) &&
                  ((slot_v[0] && slot_addr[0] == q1_addr) ||
                   (slot_v[1] && slot_addr[1] == q1_addr) ||
                   (we && waddr == q1_addr));

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed self-checking bench for regfile_wr_arb; expectations follow the
// REGFILE_ARB_RR_EN setting of the build.
module tb_regfile_wr_arb;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0, q0_addr = '0, q1_addr = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_ready, s1_ready, we, q0_hit, q1_hit;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int checks = 0;
  int failures = 0;

  regfile_wr_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_hit(q0_hit), .q1_hit(q1_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          s0v;
    logic [AW-1:0] s0a;
    logic [DW-1:0] s0d;
    logic          s1v;
    logic [AW-1:0] s1a;
    logic [DW-1:0] s1d;
    logic [AW-1:0] q0;
    logic [AW-1:0] q1;
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_r0;
    logic          e_r1;
    logic          e_h0;
    logic          e_h1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
  endtask

  // Leaves the bench at posedge+1 of the cycle after the first post-release edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, " we"}, 64'(we), 64'(1'b1));
    check({tag, " waddr"}, 64'(waddr), 64'(a));
    check({tag, " wdata"}, 64'(wdata), 64'(d));
  endtask

  initial begin
    int k0, k1;
    logic rd0;
    logic rr_build;
`ifdef REGFILE_ARB_RR_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif

    //            s0v  s0a    s0d       s1v  s1a    s1d       q0     q1     we   waddr  wdata     r0   r1   h0   h1
    vecs[0] = '{1'b1, 5'd3, 32'h11,  1'b0, 5'd0,  32'h0,   5'd3,  5'd0,  1'b0, 5'd0,  32'h0,   1'b1,1'b1,1'b0,1'b0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd3,  5'd0,  1'b0, 5'd0,  32'h0,   1'b1,1'b1,1'b1,1'b0};
    vecs[2] = '{1'b1, 5'd0, 32'hFF,  1'b0, 5'd0,  32'h0,   5'd0,  5'd3,  1'b1, 5'd3,  32'h11,  1'b1,1'b1,1'b0,1'b1};
    vecs[3] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd0,  5'd3,  1'b0, 5'd3,  32'h11,  1'b1,1'b1,1'b0,1'b0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd10, 32'h100, 5'd0,  5'd0,  1'b0, 5'd3,  32'h11,  1'b1,1'b1,1'b0,1'b0};
    vecs[5] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd11, 32'h101, 5'd11, 5'd10, 1'b0, 5'd3,  32'h11,  1'b1,1'b1,1'b0,1'b1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd12, 32'h102, 5'd11, 5'd10, 1'b1, 5'd10, 32'h100, 1'b1,1'b1,1'b1,1'b1};
    vecs[7] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd12, 5'd13, 1'b1, 5'd11, 32'h101, 1'b1,1'b1,1'b1,1'b0};
    vecs[8] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd0,  5'd12, 1'b1, 5'd12, 32'h102, 1'b1,1'b1,1'b0,1'b1};
    vecs[9] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd0,  5'd12, 1'b0, 5'd12, 32'h102, 1'b1,1'b1,1'b0,1'b0};

    // Reset state while held, then ready must wait for the first edge after release.
    #1 rst = 1'b0;
    q0_addr = 5'd3; q1_addr = 5'd0;
    step();
    step();
    check("rst we", 64'(we), 64'(1'b0));
    check("rst waddr", 64'(waddr), 64'(0));
    check("rst wdata", 64'(wdata), 64'(0));
    check("rst s0_ready", 64'(s0_ready), 64'(1'b0));
    check("rst s1_ready", 64'(s1_ready), 64'(1'b0));
    check("rst q0_hit", 64'(q0_hit), 64'(1'b0));
    #2 rst = 1'b1;
    #1;
    check("release s0_ready pre-edge", 64'(s0_ready), 64'(1'b0));
    step();
    check("release s0_ready post-edge", 64'(s0_ready), 64'(1'b1));
    check("release s1_ready post-edge", 64'(s1_ready), 64'(1'b1));

    // Single write latency, queries, zero-address discard, s1 back-to-back.
    for (int i = 0; i < 10; i++) begin
      s0_valid = vecs[i].s0v; s0_addr = vecs[i].s0a; s0_data = vecs[i].s0d;
      s1_valid = vecs[i].s1v; s1_addr = vecs[i].s1a; s1_data = vecs[i].s1d;
      q0_addr = vecs[i].q0;   q1_addr = vecs[i].q1;
      #1;
      check($sformatf("row%0d we", i), 64'(we), 64'(vecs[i].e_we));
      check($sformatf("row%0d waddr", i), 64'(waddr), 64'(vecs[i].e_waddr));
      check($sformatf("row%0d wdata", i), 64'(wdata), 64'(vecs[i].e_wdata));
      check($sformatf("row%0d s0_ready", i), 64'(s0_ready), 64'(vecs[i].e_r0));
      check($sformatf("row%0d s1_ready", i), 64'(s1_ready), 64'(vecs[i].e_r1));
      check($sformatf("row%0d q0_hit", i), 64'(q0_hit), 64'(vecs[i].e_h0));
      check($sformatf("row%0d q1_hit", i), 64'(q1_hit), 64'(vecs[i].e_h1));
      step();
    end
    q0_addr = '0; q1_addr = '0;

    // Same-edge acceptance to one address: slot 1 is older and drains first.
    do_reset();
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'hB;
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'hA;
    step();
    idle_inputs();
    #1;
    check("same-edge s0_ready", 64'(s0_ready), 64'(1'b0));
    check("same-edge s1_ready", 64'(s1_ready), 64'(1'b1));
    step();
    check_write("same-edge first", 5'd7, 32'hA);
    step();
    check_write("same-edge second", 5'd7, 32'hB);
    step();
    check("same-edge drained we", 64'(we), 64'(1'b0));

    // s1 accepted one edge before s0 to the same address: the earlier one goes first.
    do_reset();
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h55;
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'hA;
    step();
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'hB;
    s1_valid = 1'b0;
    #1;
    check("age s0_ready", 64'(s0_ready), 64'(1'b1));
    check("age s1_ready", 64'(s1_ready), 64'(1'b0));
    step();
    idle_inputs();
    #1;
    check_write("age w0", 5'd5, 32'h55);
    check("age s0_ready blocked", 64'(s0_ready), 64'(1'b0));
    step();
    check_write("age w1", 5'd7, 32'hA);
    step();
    check_write("age w2", 5'd7, 32'hB);
    step();
    check("age drained we", 64'(we), 64'(1'b0));

    // Reset pulse mid-cycle with both slots holding data.
    do_reset();
    s0_valid = 1'b1; s0_addr = 5'd20; s0_data = 32'h200;
    s1_valid = 1'b1; s1_addr = 5'd21; s1_data = 32'h201;
    step();
    idle_inputs();
    step();
    q0_addr = 5'd21; q1_addr = 5'd20;
    #1;
    check_write("pre-reset", 5'd20, 32'h200);
    check("pre-reset q0_hit", 64'(q0_hit), 64'(1'b1));
    #1 rst = 1'b0;
    #1;
    check("mid-reset we", 64'(we), 64'(1'b0));
    check("mid-reset waddr", 64'(waddr), 64'(0));
    check("mid-reset s0_ready", 64'(s0_ready), 64'(1'b0));
    check("mid-reset s1_ready", 64'(s1_ready), 64'(1'b0));
    check("mid-reset q0_hit", 64'(q0_hit), 64'(1'b0));
    check("mid-reset q1_hit", 64'(q1_hit), 64'(1'b0));
    #1 rst = 1'b1;
    #1;
    check("post-release s1_ready pre-edge", 64'(s1_ready), 64'(1'b0));
    step();
    check("post-release s0_ready", 64'(s0_ready), 64'(1'b1));
    check("post-release s1_ready", 64'(s1_ready), 64'(1'b1));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post-reset no write %0d", i), 64'(we), 64'(1'b0));
      step();
    end
    q0_addr = '0; q1_addr = '0;

    // Both sources streaming to distinct addresses.
    do_reset();
    k0 = 0; k1 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      s0_valid = 1'b1; s0_addr = AW'(16 + k0); s0_data = 32'h1000 + 32'(k0);
      s1_valid = 1'b1; s1_addr = AW'(24 + k1); s1_data = 32'h2000 + 32'(k1);
      #1;
      if (cyc >= 1) begin
        if (rr_build) begin
          check($sformatf("stream c%0d s0_ready", cyc), 64'(s0_ready), 64'(cyc % 2 == 1));
          check($sformatf("stream c%0d s1_ready", cyc), 64'(s1_ready), 64'(cyc % 2 == 0));
        end else begin
          check($sformatf("stream c%0d s1_ready", cyc), 64'(s1_ready), 64'(1'b0));
        end
      end
      if (cyc >= 2) begin
        int j;
        j = cyc - 2;
        if (!rr_build)
          check_write($sformatf("stream out%0d", j), AW'(16 + j), 32'h1000 + 32'(j));
        else if (j % 2 == 0)
          check_write($sformatf("stream out%0d", j), AW'(16 + j / 2), 32'h1000 + 32'(j / 2));
        else
          check_write($sformatf("stream out%0d", j), AW'(24 + j / 2), 32'h2000 + 32'(j / 2));
      end
      rd0 = s0_ready;
      if (s1_ready) k1++;
      step();
      if (rd0) k0++;
    end
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
